// File: rtl/cmp_sched.sv
// Two-port scheduler for the shared 32-bit compare datapath: round-robin grant,
// one operand stage (S1), and per-port response registers with flush on port 0.
module cmp_sched #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_rs1,
    input  logic [31:0]      req0_rs2,
    input  logic [2:0]       req0_funct3,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_rs1,
    input  logic [31:0]      req1_rs2,
    input  logic             req1_unsigned,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp0_taken,
    output logic             rsp0_illegal,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic             rsp1_less,
    output logic [TAG_W-1:0] rsp1_tag
);

    logic             run;
    logic             rr_prio;
    logic             s1_valid;
    logic             s1_port;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [2:0]       s1_f3;
    logic             s1_un;
    logic [TAG_W-1:0] s1_tag;

    logic [32:0] diff;
    logic        equal;
    logic        less_u;
    logic        less_s;
    logic        br_taken;
    logic        br_illegal;
    logic        lt_less;

    logic s1_retire;
    logic s1_kill;
    logic may_load;
    logic v0;
    logic gnt;
    logic accept;

    always_comb begin
        diff   = {1'b0, s1_a} + {1'b0, ~s1_b} + 33'd1;
        equal  = (diff[31:0] == '0);
        less_u = ~diff[32];
        less_s = (s1_a[31] ^ s1_b[31]) ? s1_a[31] : diff[31];

        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (s1_f3)
            3'b000:  br_taken = equal;
            3'b001:  br_taken = ~equal;
            3'b100:  br_taken = less_s;
            3'b101:  br_taken = ~less_s;
            3'b110:  br_taken = less_u;
            3'b111:  br_taken = ~less_u;
            default: br_illegal = 1'b1;
        endcase

        lt_less = s1_un ? less_u : less_s;
    end

    always_comb begin
        s1_retire = s1_valid & (s1_port ? (~rsp1_valid | rsp1_ready)
                                        : (~rsp0_valid | rsp0_ready));
        s1_kill   = flush & s1_valid & ~s1_port;
        may_load  = ~s1_valid | s1_retire;

        // Port 0 is masked out of arbitration during flush so port 1 can still win.
        v0  = req0_valid & ~flush;
        gnt = (v0 & req1_valid) ? rr_prio : (req1_valid & ~v0);

        req0_ready = run & ~flush & ~gnt & may_load;
        req1_ready = run & gnt & may_load;
        accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    end

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            rr_prio <= 1'b0;
        end else begin
            run <= 1'b1;
            if (accept)
                rr_prio <= ~gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_port  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_f3    <= '0;
            s1_un    <= 1'b0;
            s1_tag   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_port  <= gnt;
            s1_a     <= gnt ? req1_rs1 : req0_rs1;
            s1_b     <= gnt ? req1_rs2 : req0_rs2;
            s1_f3    <= req0_funct3;
            s1_un    <= req1_unsigned;
            s1_tag   <= gnt ? req1_tag : req0_tag;
        end else if (s1_retire | s1_kill) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid   <= 1'b0;
            rsp0_taken   <= 1'b0;
            rsp0_illegal <= 1'b0;
            rsp0_tag     <= '0;
        end else if (flush) begin
            rsp0_valid <= 1'b0;
        end else if (s1_retire & ~s1_port) begin
            rsp0_valid   <= 1'b1;
            rsp0_taken   <= br_taken;
            rsp0_illegal <= br_illegal;
            rsp0_tag     <= s1_tag;
        end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid <= 1'b0;
            rsp1_less  <= 1'b0;
            rsp1_tag   <= '0;
        end else if (s1_retire & s1_port) begin
            rsp1_valid <= 1'b1;
            rsp1_less  <= lt_less;
            rsp1_tag   <= s1_tag;
        end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmp_sched.sv
// Self-checking bench for cmp_sched: directed scenarios plus random traffic
// checked against per-port expected-response queues built from compare rules.
module tb_cmp_sched;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          req0_valid, req0_ready;
    logic [31:0]   req0_rs1, req0_rs2;
    logic [2:0]    req0_funct3;
    logic [TW-1:0] req0_tag;
    logic          req1_valid, req1_ready;
    logic [31:0]   req1_rs1, req1_rs2;
    logic          req1_unsigned;
    logic [TW-1:0] req1_tag;
    logic          rsp0_valid, rsp0_ready, rsp0_taken, rsp0_illegal;
    logic [TW-1:0] rsp0_tag;
    logic          rsp1_valid, rsp1_ready, rsp1_less;
    logic [TW-1:0] rsp1_tag;

    cmp_sched #(.TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req0_funct3(req0_funct3), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .req1_unsigned(req1_unsigned), .req1_tag(req1_tag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_taken(rsp0_taken), .rsp0_illegal(rsp0_illegal), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_less(rsp1_less), .rsp1_tag(rsp1_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic          res;
        logic          ill;
        int            acc;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    bit    lat_on = 1'b0;
    logic  ref_prio = 1'b0;
    logic  snap_less;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {illegal, taken} straight from the branch definitions.
    function automatic logic [1:0] ref_br(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f);
        case (f)
            3'd0:    return {1'b0, a == b};
            3'd1:    return {1'b0, a != b};
            3'd4:    return {1'b0, $signed(a) <  $signed(b)};
            3'd5:    return {1'b0, $signed(a) >= $signed(b)};
            3'd6:    return {1'b0, a <  b};
            3'd7:    return {1'b0, a >= b};
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic ref_lt(input logic [31:0] a, input logic [31:0] b, input logic un);
        return un ? (a < b) : ($signed(a) < $signed(b));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called after the negedge with inputs driven; scores the cycle, then advances.
    task automatic cycle();
        logic  a0, a1;
        logic [1:0] br;
        item_t it;
        #1;
        if (rst_n) begin
            if (req0_ready | req1_ready) begin
                chk("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
                if (req0_valid & ~flush & req1_valid)
                    chk("rr_grant", {63'd0, req1_ready}, {63'd0, ref_prio});
            end
            if (flush)
                chk("flush_blocks_r0", {63'd0, req0_ready}, 64'd0);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            if (flush) begin
                q0.delete();
            end else if (rsp0_valid & rsp0_ready) begin
                if (q0.size() == 0) begin
                    chk("rsp0_spurious", 64'd1, 64'd0);
                end else begin
                    it = q0.pop_front();
                    chk("rsp0_taken", {63'd0, rsp0_taken}, {63'd0, it.res});
                    chk("rsp0_illegal", {63'd0, rsp0_illegal}, {63'd0, it.ill});
                    chk("rsp0_tag", {60'd0, rsp0_tag}, {60'd0, it.tag});
                    if (lat_on) chk("rsp0_lat", 64'(cyc - it.acc), 64'd2);
                end
            end
            if (rsp1_valid & rsp1_ready) begin
                if (q1.size() == 0) begin
                    chk("rsp1_spurious", 64'd1, 64'd0);
                end else begin
                    it = q1.pop_front();
                    chk("rsp1_less", {63'd0, rsp1_less}, {63'd0, it.res});
                    chk("rsp1_tag", {60'd0, rsp1_tag}, {60'd0, it.tag});
                    if (lat_on) chk("rsp1_lat", 64'(cyc - it.acc), 64'd2);
                end
            end
            if (a0) begin
                br = ref_br(req0_rs1, req0_rs2, req0_funct3);
                it = '{tag: req0_tag, res: br[0], ill: br[1], acc: cyc};
                q0.push_back(it);
                ref_prio = 1'b1;
            end
            if (a1) begin
                it = '{tag: req1_tag, res: ref_lt(req1_rs1, req1_rs2, req1_unsigned),
                       ill: 1'b0, acc: cyc};
                q1.push_back(it);
                ref_prio = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive0(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [TW-1:0] t);
        req0_valid = 1'b1; req0_rs1 = a; req0_rs2 = b; req0_funct3 = f; req0_tag = t;
    endtask

    task automatic drive1(input logic [31:0] a, input logic [31:0] b,
                          input logic un, input logic [TW-1:0] t);
        req1_valid = 1'b1; req1_rs1 = a; req1_rs2 = b; req1_unsigned = un; req1_tag = t;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        req0_valid = 1'b0; req0_rs1 = '0; req0_rs2 = '0; req0_funct3 = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_rs1 = '0; req1_rs2 = '0; req1_unsigned = 1'b0; req1_tag = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
        chk("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
        chk("rst_taken", {63'd0, rsp0_taken}, 64'd0);
        chk("rst_illegal", {63'd0, rsp0_illegal}, 64'd0);
        chk("rst_less", {63'd0, rsp1_less}, 64'd0);
        chk("rst_tags", {56'd0, rsp0_tag, rsp1_tag}, 64'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Dual requests every cycle: strict alternation from port 0
        lat_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive0(pick(), pick(), 3'($urandom_range(0, 7)), TW'(i));
            drive1(pick(), pick(), 1'($urandom_range(0, 1)), TW'(i));
            #1;
            chk("dual_grant0", {63'd0, req0_ready}, {63'd0, (i % 2) == 0});
            chk("dual_grant1", {63'd0, req1_ready}, {63'd0, (i % 2) == 1});
            cycle();
        end
        idle(3);

        // Directed branch decodes, back-to-back
        begin
            logic [2:0] f3s [4];
            f3s = '{3'd4, 3'd6, 3'd5, 3'd7};
            for (int i = 0; i < 4; i++) begin
                drive0(32'hFFFF_FFFF, 32'h0000_0001, f3s[i], TW'(i + 1));
                #1;
                chk("dir_ready", {63'd0, req0_ready}, 64'd1);
                cycle();
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive0(32'h8000_0000, 32'h8000_0000, 3'(i), TW'(i + 5));
            cycle();
        end
        idle(4);
        lat_on = 1'b0;

        // rsp1 stall: head-of-line blocking, stable response, clean resume
        rsp1_ready = 1'b0;
        drive1(32'h0000_0005, 32'hFFFF_FFFF, 1'b0, TW'(1));
        cycle();
        drive1(32'h0000_0005, 32'hFFFF_FFFF, 1'b1, TW'(2));
        cycle();
        drive0(32'h1, 32'h2, 3'd4, TW'(3));
        drive1(32'h3, 32'h4, 1'b1, TW'(3));
        #1;
        snap_less = rsp1_less;
        for (int i = 0; i < 4; i++) begin
            chk("stall_r0", {63'd0, req0_ready}, 64'd0);
            chk("stall_r1", {63'd0, req1_ready}, 64'd0);
            chk("stall_valid", {63'd0, rsp1_valid}, 64'd1);
            chk("stall_tag", {60'd0, rsp1_tag}, 64'd1);
            chk("stall_less", {63'd0, rsp1_less}, {63'd0, snap_less});
            cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        idle(4);
        chk("stall_drained", 64'(q1.size()), 64'd0);

        // Flush kills port-0 work; port-1 accept in the flush cycle proceeds
        drive0(32'h9, 32'h9, 3'd0, TW'(5));
        cycle();
        req0_valid = 1'b0;
        flush = 1'b1;
        drive1(32'h1, 32'h2, 1'b1, TW'(6));
        #1;
        chk("flush_r1_ready", {63'd0, req1_ready}, 64'd1);
        cycle();
        flush = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_no_rsp0", {63'd0, rsp0_valid}, 64'd0);
            cycle();
        end
        chk("flush_p1_done", 64'(q1.size()), 64'd0);

        // Random traffic with backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_rs1 = pick();
            req0_rs2 = ($urandom_range(0, 3) == 0) ? req0_rs1 : pick();
            req0_funct3 = 3'($urandom_range(0, 7));
            req0_tag = TW'($urandom);
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_rs1 = pick();
            req1_rs2 = ($urandom_range(0, 3) == 0) ? req1_rs1 : pick();
            req1_unsigned = 1'($urandom_range(0, 1));
            req1_tag = TW'($urandom);
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle();
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        idle(6);
        chk("rand_drain0", 64'(q0.size()), 64'd0);
        chk("rand_drain1", 64'(q1.size()), 64'd0);

        // Mid-stream async reset with S1 and both response registers full
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive0(pick(), pick(), 3'd4, TW'(i));
            drive1(pick(), pick(), 1'b0, TW'(i));
            cycle();
        end
        #1;
        chk("pre_rst_full", {62'd0, rsp0_valid, rsp1_valid}, 64'd3);
        chk("pre_rst_block", {62'd0, req0_ready, req1_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        chk("mid_rst_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
        q0.delete(); q1.delete();
        ref_prio = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        drive0(32'h2, 32'h1, 3'd7, TW'(9));
        drive1(32'h2, 32'h1, 1'b1, TW'(9));
        #1;
        chk("post_rst_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
        cycle();
        cycle();
        idle(5);
        chk("final_drain0", 64'(q0.size()), 64'd0);
        chk("final_drain1", 64'(q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cmp_sched.md
# cmp_sched

Two-port scheduler for a single shared 32-bit compare datapath (subtract-based equal / signed-less / unsigned-less comparator, same function as `brc`) in the RV32I core. Port 0 serves branch resolution: BEQ/BNE/BLT/BGE/BLTU/BGEU decode from funct3 into a taken bit. Port 1 serves SLT/SLTU-style less-than queries. It arbitrates round-robin, registers operands, and returns results through per-port valid/ready response registers. Port 0 transactions can be killed by a pipeline flush.

## Interface
- `TAG_W`, default 4: width of the opaque transaction tag carried request to response.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: kills all port-0 work in flight (S1 entry and rsp0 register).
- `req0_valid` in 1 / `req0_ready` out 1: branch request handshake.
- `req0_rs1`, `req0_rs2` in 32: branch operands.
- `req0_funct3` in 3: RV32I branch funct3.
- `req0_tag` in TAG_W.
- `req1_valid` in 1 / `req1_ready` out 1: less-than request handshake.
- `req1_rs1`, `req1_rs2` in 32.
- `req1_unsigned` in 1: 1 selects SLTU semantics.
- `req1_tag` in TAG_W.
- `rsp0_valid` out 1 / `rsp0_ready` in 1; `rsp0_taken` out 1; `rsp0_illegal` out 1; `rsp0_tag` out TAG_W.
- `rsp1_valid` out 1 / `rsp1_ready` in 1; `rsp1_less` out 1; `rsp1_tag` out TAG_W.

## Operation
- Compare function on S1 operands a, b:
  - diff = a + ~b + 1 (32-bit), cout = carry out.
  - equal = (diff == 0).
  - less_u = ~cout.
  - less_s = (a[31] ^ b[31]) ? a[31] : diff[31].
  - un = funct3[1] for port 0, `req1_unsigned` for port 1.
- Port 0 decode, taken =
  - 000: equal; 001: ~equal.
  - 100: less_s; 101: ~less_s.
  - 110: less_u; 111: ~less_u.
  - 010/011: taken=0 and illegal=1. Illegal is 0 for all legal encodings.
- Port 1: less = un ? less_u : less_s.
- State:
  - `rr_prio` (1 bit, the port that wins a tie).
  - S1 stage: valid, port, a, b, funct3/un, tag.
  - rsp0 and rsp1 output registers.
- S1 may load when S1 is empty, or when S1 retires this cycle. S1 retires when its target rsp register is empty or is being popped this cycle (rsp_valid & rsp_ready).
- Grant:
  - Only one valid: that port.
  - Both valid: port `rr_prio`.
  - `reqK_ready` = (grant==K) & S1 may load; additionally `req0_ready` = 0 while `flush`=1.
  - A req ready may depend on the other port's valid; no valid may depend on ready.
- `rr_prio` updates only on an accepted grant: after accepting port K, `rr_prio` = ~K. With continuous dual requests, grants alternate strictly.
- Flush, same cycle:
  - S1 holding port 0 is invalidated without writing rsp0.
  - rsp0_valid is cleared.
  - No port-0 accept.
  - Port-1 traffic is unaffected, including a port-1 accept that same cycle.
- Response registers hold value and tag stable while valid & ~ready.

## Timing
- Reset (async assert, sync-safe release): all valids 0, `rr_prio`=0, `rsp0_taken`/`rsp0_illegal`/`rsp1_less`=0, tags 0, `req0_ready`/`req1_ready`=0 while in reset.
- Latency: accept at edge N → S1 valid in cycle N+1 → rsp valid in cycle N+2 (2 cycles). Throughput is 1 request/cycle aggregate with no bubbles while responses drain.
- Backpressure: if rsp1 is stalled, an S1 entry for port 1 holds. Both req readies drop, including port 0, because S1 is blocked (head-of-line blocking is accepted by design).
- Pop and refill of the same rsp register in one cycle is permitted (full throughput).
- Flush has priority over S1 retire into rsp0 and over the rsp0 pop in the same cycle.
- Mid-operation reset clears all in-flight work; there are no partial responses after release.

## Test plan
- Port 0 only, rs1=0xFFFF_FFFF, rs2=0x0000_0001:
  - funct3=100 → taken=1; 110 → taken=0; 101 → taken=0; 111 → taken=1.
  - Each response arrives exactly 2 cycles after accept.
- Port 0, rs1=rs2=0x8000_0000: 000 → taken=1, 001 → 0. Then funct3=010 → taken=0, illegal=1, tag echoed.
- Both ports valid every cycle for 8 cycles, rsp readies tied 1:
  - Grants alternate 0,1,0,1… starting with port 0 after reset.
  - Tags return in order per port, with no gaps.
- rsp1_ready=0 with port-1 entries queued: rsp1 holds less/tag stable, S1 stalls, both req readies are 0. Raising rsp1_ready resumes with no loss or duplication.
- Port-0 request accepted at edge N, `flush` high in cycle N+1: no rsp0_valid ever appears for that tag. A port-1 request accepted in cycle N+1 completes normally.
- Assert `rst_n` low asynchronously mid-stream with S1 and both rsp registers full: all valids drop immediately, `rr_prio`=0 after release, and the first dual request grants port 0.
